poly_ram_reader: RTL
====================

// Module: poly_ram_reader
// PURPOSE
//  Read-side engine for a 12-bit x 512 true dual-port coefficient RAM (1-cycle read latency).
//  On a start pulse it fetches N_COEFF coefficients, two per cycle (port A even index,
//  port B odd index), and emits them as {odd,even} pairs on a valid/ready stream.
//  Sits between the NTT core's coefficient RAM and the result/output path.
// PARAMETERS
//  ADDR_W   9    RAM address width
//  DATA_W   12   coefficient width
//  N_COEFF  256  coefficients per transfer; power of 2, >= 4, <= 2**ADDR_W
// PORTS
//  clk         in   1         rising-edge clock
//  rst_n       in   1         asynchronous active-low reset
//  start       in   1         1-cycle request; sampled only in IDLE
//  base_addr   in   ADDR_W    polynomial base address, latched on accepted start
//  busy        out  1         transfer in progress
//  done        out  1         1-cycle pulse after the last beat is accepted
//  ram_addr_a  out  ADDR_W    RAM port A address (even coefficient)
//  ram_addr_b  out  ADDR_W    RAM port B address (odd coefficient)
//  ram_we_a    out  1         tied 0 (read-only engine)
//  ram_we_b    out  1         tied 0
//  ram_q_a     in   DATA_W    RAM port A read data, valid 1 cycle after address
//  ram_q_b     in   DATA_W    RAM port B read data
//  m_valid     out  1         output beat valid
//  m_ready     in   1         downstream accepts beat
//  m_data      out  2*DATA_W  {coef[2k+1], coef[2k]}
//  m_last      out  1         high with final pair (k = N_COEFF/2-1)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, pair counter 0, FIFO empty, in-flight flag 0.
//  - FSM: IDLE -start-> RUN (latch base, k=0, busy=1); RUN -last pair issued-> DRAIN;
//    DRAIN -last beat handshaken-> IDLE with done=1 for one cycle and busy=0 that same cycle.
//  - start while busy ignored; start in the done cycle is accepted (FSM already IDLE).
//  - Issue: in RUN, pair k is issued when fifo_count + inflight < 3 (registered state only;
//    no combinational m_ready->ram_addr path). Issuing drives ram_addr_a = base+2k,
//    ram_addr_b = base+2k+1, both modulo 2**ADDR_W (wrap 511->0); sets inflight, k++.
//  - Addresses hold last value when not issuing; they only need to be valid in issue cycles.
//  - Capture: cycle after an issue, {ram_q_b, ram_q_a} and last flag pushed into 3-entry FIFO.
//  - Output: m_data/m_valid/m_last driven from registered FIFO head; pop on m_valid&&m_ready.
//    m_data and m_last stable while m_valid && !m_ready. Push and pop same cycle legal.
//  - Latency: start in cycle 0 -> pair 0 address in cycle 1 -> m_valid in cycle 3.
//    Throughput 1 pair/cycle with m_ready held high; N_COEFF/2 beats, no gaps.
//  - FIFO cannot overflow: credit rule bounds count+inflight <= 3.
//  - rst_n low mid-transfer: immediate clear to reset state; partial data discarded;
//    a new start restarts at pair 0.
// CONFIGURATION
//  POLY_RD_BITREV_EN defined: coefficient index j read from base + bitrev(j) over
//    log2(N_COEFF) bits (bit-reversed NTT output reordered to natural order);
//    ram_addr_a = base+bitrev(2k), ram_addr_b = base+bitrev(2k+1); stream order unchanged.
//  Undefined: natural addressing as above. Timing/handshake identical in both builds.
// TESTING
//  1 RAM[i]=i, base=0, m_ready=1, start@cycle0 -> m_valid@3, beat k={2k+1,2k}, beat127
//    ={255,254} with m_last=1 @cycle130, done @131, busy low @131.
//  2 Same, m_ready random (50%) -> 128 beats, no loss/dup, data held while stalled,
//    fifo_count+inflight never >3.
//  3 base=0x1C0, RAM[i]=i -> beat 31 {0x1FF,0x1FE}, beat 32 {0x001,0x000} (wrap).
//  4 start pulsed at cycles 0 and 20 -> second ignored, one done; start on done cycle
//    -> new transfer, first beat 3 cycles later.
//  5 rst_n low after beat 50 accepted -> m_valid/busy/m_data 0 asynchronously; restart
//    -> beat 0 = {1,0}.
//  6 POLY_RD_BITREV_EN, N=256, base=0, RAM[i]=i -> beat 0 {0x80,0x00}, beat 1 {0xC0,0x40}.

Source files
------------

// File: rtl/poly_ram_reader.sv
// poly_ram_reader: read-side engine for a 12-bit x 512 dual-port coefficient RAM.
// Fetches N_COEFF coefficients two per cycle (even index on port A, odd index on
// port B) and streams them as {odd, even} pairs on a valid/ready interface.
// A credit rule keeps RAM reads in flight plus FIFO occupancy at or below 3.
// This bounds the 3-entry skid FIFO without a combinational m_ready->address path.
// Build option: define POLY_RD_BITREV_EN to read coefficient j from base + bitrev(j),
// which returns bit-reversed NTT output in natural order.

module poly_ram_reader #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 12,
    parameter int N_COEFF = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     ram_addr_a,
    output logic [ADDR_W-1:0]     ram_addr_b,
    output logic                  ram_we_a,
    output logic                  ram_we_b,
    input  logic [DATA_W-1:0]     ram_q_a,
    input  logic [DATA_W-1:0]     ram_q_b,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [2*DATA_W-1:0]   m_data,
    output logic                  m_last
);

    localparam int LOG2N = $clog2(N_COEFF);
    localparam int K_W   = LOG2N - 1;
    localparam logic [K_W-1:0] K_MAX = {K_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t                r_state;
    logic [ADDR_W-1:0]     r_base;
    logic [K_W-1:0]        r_k;
    logic [ADDR_W-1:0]     r_addrA;
    logic [ADDR_W-1:0]     r_addrB;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_inflight;
    logic                  r_inflightLast;
    logic [1:0]            r_count;
    logic [2*DATA_W-1:0]   r_fifoData [0:2];
    logic                  r_fifoLast [0:2];

    logic [K_W-1:0]        w_kNext;
    logic [2:0]            w_credit;
    logic                  w_issue;
    logic                  w_valid;
    logic                  w_pop;
    logic [1:0]            w_wrIdx;

    // Physical RAM address of coefficient index idx relative to base; wraps modulo 2**ADDR_W.
    function automatic logic [ADDR_W-1:0] coefAddr(input logic [ADDR_W-1:0] base,
                                                   input logic [LOG2N-1:0]  idx);
        logic [LOG2N-1:0] w_rev;
`ifdef POLY_RD_BITREV_EN
        for (int b = 0; b < LOG2N; b++) begin
            w_rev[b] = idx[LOG2N-1-b];
        end
`else
        w_rev = idx;
`endif
        return base + ADDR_W'(w_rev);
    endfunction

    assign w_kNext  = r_k + K_W'(1);
    assign w_credit = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_issue  = (r_state == ST_RUN) && (w_credit < 3'd3);
    assign w_valid  = (r_count != 2'd0);
    assign w_pop    = w_valid && m_ready;
    assign w_wrIdx  = r_count - {1'b0, w_pop};

    assign busy       = r_busy;
    assign done       = r_done;
    assign ram_addr_a = r_addrA;
    assign ram_addr_b = r_addrB;
    assign ram_we_a   = 1'b0;
    assign ram_we_b   = 1'b0;
    assign m_valid    = w_valid;
    assign m_data     = r_fifoData[0];
    assign m_last     = r_fifoLast[0] & w_valid;

    // Control FSM: accept start, issue address pairs under credit, and wait for the last beat to drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_base         <= '0;
            r_k            <= '0;
            r_addrA        <= '0;
            r_addrB        <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_inflight     <= 1'b0;
            r_inflightLast <= 1'b0;
        end else begin
            r_done         <= 1'b0;
            r_inflight     <= w_issue;
            r_inflightLast <= w_issue && (r_k == K_MAX);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_base  <= base_addr;
                        r_k     <= '0;
                        r_addrA <= coefAddr(base_addr, LOG2N'(0));
                        r_addrB <= coefAddr(base_addr, LOG2N'(1));
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_issue) begin
                        r_k     <= w_kNext;
                        r_addrA <= coefAddr(r_base, {w_kNext, 1'b0});
                        r_addrB <= coefAddr(r_base, {w_kNext, 1'b1});
                        if (r_k == K_MAX) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && r_fifoLast[0]) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Shift-register FIFO: entry 0 is the output head, captured RAM data is written behind the survivors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                r_fifoData[i] <= '0;
                r_fifoLast[i] <= 1'b0;
            end
        end else begin
            if (w_pop) begin
                for (int i = 0; i < 2; i++) begin
                    r_fifoData[i] <= r_fifoData[i+1];
                    r_fifoLast[i] <= r_fifoLast[i+1];
                end
            end
            if (r_inflight) begin
                r_fifoData[w_wrIdx] <= {ram_q_b, ram_q_a};
                r_fifoLast[w_wrIdx] <= r_inflightLast;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

endmodule
